// File: rtl/seg_pkg.sv
// Seven-segment constants and BCD decode shared by the timer display blocks.
package seg_pkg;

  localparam int DP_BIT = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;

  // Segment order {a,b,c,d,e,f,g,dp}; codes above 9 never occur in the chain.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Free-running digit scanner: dwell counter, digit index and one-hot enable.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  localparam int IW     = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [IW-1:0]     idx_nxt,
  output logic [DIGITS-1:0] seg_en
);

  localparam int SCAN_N = CLK_HZ / SCAN_HZ;
  localparam int SW     = $clog2(SCAN_N);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_N - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;

  // idx_nxt is exported so the segment register can follow the enable on the same edge.
  always_comb begin
    idx_nxt = idx;
    if (scan_cnt == SCAN_LAST) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_en   <= DIGITS'(1);
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
      idx      <= idx_nxt;
      seg_en   <= DIGITS'(1) << idx_nxt;
    end
  end

endmodule

// File: rtl/seg_timer_disp.sv
// Elapsed-time BCD counter with multiplexed seven-segment output and sticky overflow.
// Define SEG_TIMER_LZB_EN to blank leading zeros above the decimal-point digit.
module seg_timer_disp
  import seg_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4,
  parameter int DP_POS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  clear,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     seg_en,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  overflow
);

  localparam int PRE_N = CLK_HZ / TICK_HZ;
  localparam int PW    = $clog2(PRE_N);
  localparam int IW    = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_N - 1);

  logic [PW-1:0]         pre;
  logic                  tick;
  logic                  carry;
  logic                  wrap;
  logic [4*DIGITS-1:0]   count_inc;
  logic [4*DIGITS-1:0]   count_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [3:0]            digit;
  logic                  blank;
  logic [7:0]            seg_nxt;
`ifdef SEG_TIMER_LZB_EN
  logic                  lead_zero;
`endif

  seg_scan #(
    .DIGITS  (DIGITS),
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .idx_nxt (idx_nxt),
    .seg_en  (seg_en)
  );

  assign tick = run && (pre == PRE_LAST);

  // Ripple the tick through the decades; a carry out of the top digit is the wrap.
  always_comb begin
    carry     = tick;
    count_inc = count_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap      = carry;
    count_nxt = clear ? '0 : count_inc;
  end

  // Decode from the next count so seg_out never lags count_bcd.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
`ifdef SEG_TIMER_LZB_EN
    lead_zero = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_TIMER_LZB_EN
      lead_zero = lead_zero && (count_nxt[4*i +: 4] == 4'd0);
`endif
      if (IW'(i) == idx_nxt) begin
        digit = count_nxt[4*i +: 4];
`ifdef SEG_TIMER_LZB_EN
        blank = lead_zero && (i > DP_POS);
`endif
      end
    end
    seg_nxt = blank ? SEG_BLANK : bcd_to_seg(digit);
    if (idx_nxt == IW'(DP_POS)) begin
      seg_nxt[DP_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      count_bcd <= '0;
      overflow  <= 1'b0;
      seg_out   <= SEG_0;
    end else begin
      if (clear) begin
        pre <= '0;
      end else if (run) begin
        pre <= tick ? '0 : pre + PW'(1);
      end
      count_bcd <= count_nxt;
      if (clear) begin
        overflow <= 1'b0;
      end else if (wrap) begin
        overflow <= 1'b1;
      end
      seg_out <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_timer_disp.sv
// Scoreboard bench for seg_timer_disp: integer-time reference model plus a fast-tick wrap instance.
`timescale 1ns/1ps
module tb_seg_timer_disp;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int SCAN_HZ = 250;
  localparam int DIGITS  = 4;
  localparam int DP_POS  = 1;
  localparam int PRE_N   = CLK_HZ / TICK_HZ;
  localparam int SCAN_N  = CLK_HZ / SCAN_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  seg_out;
  logic [3:0]  seg_en;
  logic [15:0] count_bcd;
  logic        overflow;

  logic        run2 = 1'b0;
  logic        clear2 = 1'b0;
  logic [7:0]  seg_out2;
  logic [2:0]  seg_en2;
  logic [11:0] count2;
  logic        overflow2;

  always #5 clk = ~clk;

  seg_timer_disp #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(DIGITS), .DP_POS(DP_POS)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .clear(clear),
    .seg_out(seg_out), .seg_en(seg_en), .count_bcd(count_bcd), .overflow(overflow)
  );

  // Two clocks per tick so a full 3-digit wrap takes only 2000 cycles.
  seg_timer_disp #(
    .CLK_HZ(1000), .TICK_HZ(500), .SCAN_HZ(250), .DIGITS(3), .DP_POS(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .run(run2), .clear(clear2),
    .seg_out(seg_out2), .seg_en(seg_en2), .count_bcd(count2), .overflow(overflow2)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
    logic [3:0]  en;
    logic [7:0]  seg;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  int   m_cnt;
  int   m_pre;
  int   m_n;
  bit   m_ovf;

  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(int v, int k);
    int p = 1;
    logic [7:0] s;
    for (int j = 0; j < k; j++) p *= 10;
    s = seg_tab[(v / p) % 10];
`ifdef SEG_TIMER_LZB_EN
    if (k > DP_POS && v < p) s = 8'h00;
`endif
    if (k == DP_POS) s[0] = 1'b1;
    return s;
  endfunction

  // Elapsed time kept as a plain tick count; display derived from it arithmetically.
  task automatic step(input bit r, input bit c);
    exp_t e;
    int   k;
    run   = r;
    clear = c;
    if (c) begin
      m_cnt = 0; m_pre = 0; m_ovf = 0;
    end else if (r) begin
      if (m_pre == PRE_N - 1) begin
        m_pre = 0;
        if (m_cnt == 9999) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt++;
      end else begin
        m_pre++;
      end
    end
    m_n++;
    k     = (m_n / SCAN_N) % DIGITS;
    e.cnt = to_bcd(m_cnt);
    e.ovf = m_ovf;
    e.en  = 4'(1 << k);
    e.seg = exp_seg(m_cnt, k);
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    run = 0; clear = 0; run2 = 0; clear2 = 0;
    rst = 1'b1;
    #1;
    check("rst_count", count_bcd, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_seg_en", seg_en, 4'b0001);
    check("rst_seg_out", seg_out, 8'hFC);
    #1;
    rst = 1'b0;
    m_cnt = 0; m_pre = 0; m_ovf = 0; m_n = 0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("sb_count", count_bcd, e.cnt);
      check("sb_ovf", overflow, e.ovf);
      check("sb_seg_en", seg_en, e.en);
      check("sb_seg_out", seg_out, e.seg);
    end
  end

  task automatic step2(input bit r, input bit c);
    run2   = r;
    clear2 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);

    // Count to 1.0 and look at the dp digit.
    do_reset();
    repeat (100) step(1, 0);
    check("t1_count", count_bcd, 16'h0010);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (seg_en == 4'b0010) begin
        found = 1;
        check("t1_dig1_seg", seg_out, 8'h61);
      end else begin
        step(0, 0);
      end
    end
    if (!found) check("t1_dig1_timeout", 32'd0, 32'd1);

    // Partial tick survives a pause.
    do_reset();
    repeat (25) step(1, 0);
    repeat (50) step(0, 0);
    repeat (5) step(1, 0);
    check("t2_count", count_bcd, 16'h0003);

    // Clear coinciding with a tick.
    do_reset();
    repeat (420) step(1, 0);
    check("t3_count42", count_bcd, 16'h0042);
    repeat (9) step(1, 0);
    check("t3_pre_tick", count_bcd, 16'h0042);
    step(1, 1);
    check("t3_clear_wins", count_bcd, 16'h0000);
    check("t3_ovf", overflow, 1'b0);

    // Randomised run/clear traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    step(0, 0);

    // All-9s wrap and sticky overflow on the fast-tick instance.
    do_reset();
    repeat (1998) step2(1, 0);
    check("t5_all9", count2, 12'h999);
    check("t5_ovf_pre", overflow2, 1'b0);
    repeat (2) step2(1, 0);
    check("t5_wrap", count2, 12'h000);
    check("t5_ovf_set", overflow2, 1'b1);
    repeat (2) step2(1, 0);
    check("t5_after", count2, 12'h001);
    check("t5_ovf_sticky", overflow2, 1'b1);
    step2(0, 1);
    check("t5_clr_count", count2, 12'h000);
    check("t5_clr_ovf", overflow2, 1'b0);
    step2(0, 0);

    @(negedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d passing", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/seg_timer_disp.md
# seg_timer_disp

Parametrised elapsed-time display driver for the car's multiplexed seven-segment bank. It holds a DIGITS-wide cascaded BCD counter advancing once per 1/TICK_HZ second while `run` is high, and scans it onto the digits with a decimal point and sticky overflow. It generalises the fixed 4-digit timer display and drives `seg_out`/`seg_en` directly from the top level. The top FSM drives `run` in any moving state and `clear` in the off state.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 10: count increment rate (10 gives a 0.1 s LSD). CLK_HZ/TICK_HZ must be an integer ≥ 2.
- SCAN_HZ, 1000: per-digit dwell rate. CLK_HZ/SCAN_HZ must be an integer ≥ 2.
- DIGITS, 4: number of digits, 2..8.
- DP_POS, 1: digit index that lights `dp` (0 = LSD). Must be less than DIGITS.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  count enable; prescaler and count hold while low.
- clear  in  1  synchronous clear of count, prescaler and overflow; overrides `run`.
- seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, active-high.
- seg_en  out  DIGITS  one-hot digit enable, bit0 = LSD, active-high.
- count_bcd  out  4*DIGITS  current count; nibble i is digit i.
- overflow  out  1  sticky; set when the count wraps from all-9s.

## Operation
- Reset values: count_bcd = 0, overflow = 0, prescaler = 0, scan counter = 0, digit index = 0, seg_en = 1 (digit 0), seg_out = 8'b1111_1100 ("0", dp off).
- Prescaler counts 0..CLK_HZ/TICK_HZ−1 only while `run`=1. At its terminal value it produces a one-cycle `tick` and returns to 0.
- While `run`=0 the prescaler holds its value, so a partial tick is retained across a pause.
- On `tick`, digit 0 increments. Any digit at 9 rolls to 0 and carries into the next digit.
- All-9s plus `tick` wraps the count to all-0s and sets `overflow`. `overflow` stays set until `clear` or `rst`.
- `clear`=1 zeroes count, prescaler and overflow on the next edge, regardless of `run` or `tick`.
- Scan counter runs freely, independent of `run` and `clear`. At its terminal value CLK_HZ/SCAN_HZ−1, the digit index advances, wrapping from DIGITS−1 to 0.
- Decode: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex, dp = 0).
- `dp` is OR'd in when the digit index equals DP_POS.
- Arithmetic is BCD only; no divide or modulo. Prescaler width is $clog2(CLK_HZ/TICK_HZ), scan counter width is $clog2(CLK_HZ/SCAN_HZ), digit index width is $clog2(DIGITS) (minimum 1).

## Timing
- `tick` to count_bcd update: 1 cycle (count_bcd is registered).
- `seg_en` and `seg_out` are registered on the same edge from the same digit index, so they are always mutually aligned. A count change appears on `seg_out` no later than the next edge at which that digit is selected.
- Clear latency: 1 cycle on count_bcd and overflow.
- Simultaneous `tick` and `clear`: clear wins; the count is 0 with no increment.
- Asynchronous `rst` mid-scan forces all reset values immediately. The first post-reset digit advance occurs after CLK_HZ/SCAN_HZ cycles.

## Configuration
- Macro: SEG_TIMER_LZB_EN.
- Defined: leading-zero blanking. A digit with index > DP_POS whose value and all higher digits' values are 0 outputs seg_out = 8'h00 while selected. The reset value of seg_out is unchanged.
- Undefined: every digit shows its decoded value, including leading zeros.

## Structure
- Shared package `seg_pkg` holds:
  - the 7-segment constants and the `bcd_to_seg` function;
  - the dp bit index;
  - the blank pattern 8'h00.
- Sub-module `seg_scan`, parametrised by DIGITS, CLK_HZ and SCAN_HZ, holds:
  - the scan counter;
  - the digit index;
  - the one-hot `seg_en` register.
- The top level holds the prescaler, the BCD chain, overflow and the seg_out mux/decode.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100, SCAN_HZ=250, DIGITS=4, DP_POS=1, giving 10 clocks per tick and 4 clocks per digit.
- Reset then `run`=1 for 100 clocks → count_bcd = 16'h0010. Digit 1 selected → seg_out = 8'h61 ("1" with dp).
- `run`=1 for 25 clocks, `run`=0 for 50 clocks, `run`=1 for 5 clocks → count_bcd = 16'h0003 (partial tick retained).
- Preload to 16'h9999 (run 99990 clocks) then one more tick → count_bcd = 0, overflow = 1. `clear` pulse → overflow = 0.
- `clear`=1 in the same cycle as `tick` with count 16'h0042 → next cycle count_bcd = 0.
- Free scan over 16 clocks → seg_en sequence 0001, 0010, 0100, 1000 (4 clocks each), then repeats. seg_out matches the selected digit every cycle.
- With SEG_TIMER_LZB_EN, count 16'h0005 → digits 2 and 3 give seg_out = 00, digit 1 gives FD, digit 0 gives B6.
